// File: rtl/fir_xifu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fir_xifu_ctrl
// Function : FIR eXtension unit control/datapath. Holds the tap memory and
//            the sample delay line, and runs one sequential single-MAC FIR
//            pass per accepted sample. The result goes to the execute stage.
// Option   : FIR_XIFU_SATURATE_EN - saturate the result to DATA_W instead
//            of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module fir_xifu_ctrl #(
  parameter int NUM_TAPS = 8,
  parameter int DATA_W   = 16,
  parameter int ACC_W    = 40,
  parameter int SHIFT    = 15
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        wb_tap_valid_i,
  input  logic [31:0] wb_tap_i,
  input  logic        wb_sample_valid_i,
  input  logic [31:0] wb_sample_i,
  output logic        wb_ready_o,
  output logic        ex_valid_o,
  input  logic        ex_ready_i,
  output logic [31:0] ex_sample_o,
  output logic        busy_o
);

  localparam int                 c_idx_w = $clog2(NUM_TAPS);
  localparam logic [c_idx_w-1:0] c_last  = c_idx_w'(NUM_TAPS - 1);
  localparam logic [c_idx_w-1:0] c_one   = c_idx_w'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic signed [DATA_W-1:0]   r_tap [NUM_TAPS];
  logic signed [DATA_W-1:0]   r_x   [NUM_TAPS];
  logic        [c_idx_w-1:0]  r_tap_ptr;
  logic        [c_idx_w-1:0]  r_idx;
  logic signed [ACC_W-1:0]    r_acc;

  logic                       w_tap_we;
  logic                       w_sample_we;
  logic                       w_last;
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_shifted;
  logic signed [DATA_W-1:0]   w_y;
  logic                       w_unused;

  assign wb_ready_o  = (r_state == ST_IDLE) && !clear_i;
  assign w_tap_we    = wb_tap_valid_i && wb_ready_o;
  assign w_sample_we = wb_sample_valid_i && wb_ready_o;
  assign w_last      = (r_idx == c_last);
  assign w_prod      = r_x[r_idx] * r_tap[r_idx];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clear_i) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_sample_we) w_state_nxt = ST_MAC;
        ST_MAC:  if (w_last)      w_state_nxt = ST_DONE;
        ST_DONE: if (ex_ready_i)  w_state_nxt = ST_IDLE;
        default:                  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tap_ptr <= '0;
      r_idx     <= '0;
      r_acc     <= '0;
      for (int k = 0; k < NUM_TAPS; k++) begin
        r_tap[k] <= '0;
        r_x[k]   <= '0;
      end
    end else if (clear_i) begin
      r_tap_ptr <= '0;
      r_idx     <= '0;
      r_acc     <= '0;
      for (int k = 0; k < NUM_TAPS; k++) begin
        r_tap[k] <= '0;
        r_x[k]   <= '0;
      end
    end else begin
      // Tap and sample writes can land together; the MAC reads the new tap next cycle.
      if (w_tap_we) begin
        r_tap[r_tap_ptr] <= wb_tap_i[DATA_W-1:0];
        r_tap_ptr        <= r_tap_ptr + c_one;
      end
      if (w_sample_we) begin
        r_x[0] <= wb_sample_i[DATA_W-1:0];
        for (int k = 1; k < NUM_TAPS; k++) begin
          r_x[k] <= r_x[k-1];
        end
        r_acc <= '0;
        r_idx <= '0;
      end else if (r_state == ST_MAC) begin
        r_acc <= r_acc + {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
        r_idx <= r_idx + c_one;
      end
    end
  end

  assign w_shifted = r_acc >>> SHIFT;

`ifdef FIR_XIFU_SATURATE_EN
  localparam logic signed [ACC_W-1:0] c_sat_max =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] c_sat_min =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  always_comb begin
    w_y = w_shifted[DATA_W-1:0];
    if (w_shifted > c_sat_max) begin
      w_y = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (w_shifted < c_sat_min) begin
      w_y = {1'b1, {(DATA_W-1){1'b0}}};
    end
  end

  assign w_unused = ^{wb_tap_i[31:DATA_W], wb_sample_i[31:DATA_W]};
`else
  assign w_y      = w_shifted[DATA_W-1:0];
  assign w_unused = ^{wb_tap_i[31:DATA_W], wb_sample_i[31:DATA_W],
                      w_shifted[ACC_W-1:DATA_W]};
`endif

  assign ex_valid_o  = (r_state == ST_DONE);
  assign ex_sample_o = (r_state == ST_DONE) ? {{(32-DATA_W){w_y[DATA_W-1]}}, w_y} : 32'd0;
  assign busy_o      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fir_xifu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_xifu_ctrl
// Function : Self-checking bench for fir_xifu_ctrl (NUM_TAPS=4, DATA_W=16),
//            one instance with SHIFT=0 and one with SHIFT=15.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_xifu_ctrl;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        clear_i = 1'b0;
  logic        tap_v = 1'b0;
  logic [31:0] tap_d = 32'd0;
  logic        samp_v = 1'b0;
  logic [31:0] samp_d = 32'd0;
  logic        ex_ready = 1'b1;

  logic        ready0, valid0, busy0;
  logic        ready1, valid1, busy1;
  logic [31:0] s0, s1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fir_xifu_ctrl #(.NUM_TAPS(N), .DATA_W(16), .ACC_W(40), .SHIFT(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i),
    .wb_tap_valid_i(tap_v), .wb_tap_i(tap_d),
    .wb_sample_valid_i(samp_v), .wb_sample_i(samp_d),
    .wb_ready_o(ready0), .ex_valid_o(valid0), .ex_ready_i(ex_ready),
    .ex_sample_o(s0), .busy_o(busy0)
  );

  fir_xifu_ctrl #(.NUM_TAPS(N), .DATA_W(16), .ACC_W(40), .SHIFT(15)) dut1 (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i),
    .wb_tap_valid_i(tap_v), .wb_tap_i(tap_d),
    .wb_sample_valid_i(samp_v), .wb_sample_i(samp_d),
    .wb_ready_o(ready1), .ex_valid_o(valid1), .ex_ready_i(ex_ready),
    .ex_sample_o(s1), .busy_o(busy1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a result is the full dot product computed at acceptance,
  // shown after N cycles and held until the execute stage takes it.
  shortint m_tap [N];
  shortint m_x   [N];
  int      m_ptr, m_cnt, m_y0, m_y1;
  bit      m_have;
  longint  m_acc;

  function automatic int reduce(input longint acc, input int sh);
    longint v;
    v = acc >>> sh;
`ifdef FIR_XIFU_SATURATE_EN
    if (v > 32767) v = 32767;
    else if (v < -32768) v = -32768;
`else
    v = v & 64'hFFFF;
    if (v >= 32768) v = v - 65536;
`endif
    return int'(v);
  endfunction

  task automatic model_zero();
    for (int i = 0; i < N; i++) begin
      m_tap[i] = 0;
      m_x[i]   = 0;
    end
    m_ptr = 0; m_cnt = 0; m_have = 0; m_y0 = 0; m_y1 = 0;
  endtask

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      model_zero();
    end else if (clear_i) begin
      model_zero();
    end else if (m_have) begin
      if (ex_ready) m_have = 0;
    end else if (m_cnt > 0) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) m_have = 1;
    end else begin
      if (tap_v) begin
        m_tap[m_ptr] = shortint'(tap_d[15:0]);
        m_ptr = (m_ptr + 1) % N;
      end
      if (samp_v) begin
        for (int k = N - 1; k > 0; k--) m_x[k] = m_x[k-1];
        m_x[0] = shortint'(samp_d[15:0]);
        m_acc = 0;
        for (int k = 0; k < N; k++) m_acc += longint'(m_x[k]) * longint'(m_tap[k]);
        m_y0 = reduce(m_acc, 0);
        m_y1 = reduce(m_acc, 15);
        m_cnt = N;
      end
    end
  end

  always @(posedge clk) begin
    logic idle;
    #1;
    idle = (m_cnt == 0) && !m_have;
    chk("ready0", {31'b0, ready0}, {31'b0, idle && !clear_i});
    chk("ready1", {31'b0, ready1}, {31'b0, idle && !clear_i});
    chk("valid0", {31'b0, valid0}, {31'b0, m_have});
    chk("valid1", {31'b0, valid1}, {31'b0, m_have});
    chk("busy0",  {31'b0, busy0},  {31'b0, !idle});
    chk("busy1",  {31'b0, busy1},  {31'b0, !idle});
    chk("sample0", s0, m_have ? m_y0 : 32'd0);
    chk("sample1", s1, m_have ? m_y1 : 32'd0);
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wait_ready", {31'b0, ready0}, 32'd1);
  endtask

  task automatic put_tap(input logic [31:0] v);
    wait_ready();
    tap_v = 1'b1; tap_d = v;
    @(negedge clk);
    tap_v = 1'b0;
  endtask

  task automatic put_sample(input logic [31:0] v);
    wait_ready();
    samp_v = 1'b1; samp_d = v;
    @(negedge clk);
    samp_v = 1'b0;
  endtask

  task automatic get_result(input string name, input bit use1, input logic [31:0] exp, input int lat);
    int n = 0;
    while (!valid0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_vld"}, {31'b0, valid0}, 32'd1);
    if (lat >= 0) chk({name, "_lat"}, n, lat);
    chk(name, use1 ? s1 : s0, exp);
    @(negedge clk);
  endtask

  task automatic clear_pulse();
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int step_exp [4];
    int imp_exp [3];
    step_exp = '{1, 3, 6, 10};
    imp_exp  = '{32'h3FFF, 32'h1FFF, 32'h0000};

    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    chk("rst_ready", {31'b0, ready0}, 32'd1);
    chk("rst_valid", {31'b0, valid0}, 32'd0);
    chk("rst_sample", s0, 32'd0);
    chk("rst_busy", {31'b0, busy0}, 32'd0);

    // Step response
    put_tap(1); put_tap(2); put_tap(3); put_tap(4);
    for (int i = 0; i < 4; i++) begin
      put_sample(32'd1);
      get_result("step", 1'b0, step_exp[i], N);
    end

    // Impulse response on the SHIFT=15 instance
    clear_pulse();
    put_tap(32'h4000); put_tap(32'h2000); put_tap(0); put_tap(0);
    put_sample(32'h7FFF); get_result("impulse", 1'b1, imp_exp[0], N);
    put_sample(32'h0);    get_result("impulse", 1'b1, imp_exp[1], N);
    put_sample(32'h0);    get_result("impulse", 1'b1, imp_exp[2], N);

    // Overflow
    clear_pulse();
    for (int i = 0; i < 4; i++) put_tap(32'h7FFF);
    for (int i = 0; i < 4; i++) begin
      put_sample(32'h7FFF);
`ifdef FIR_XIFU_SATURATE_EN
      get_result("overflow", 1'b0, 32'h0000_7FFF, N);
`else
      get_result("overflow", 1'b0, i + 1, N);
`endif
    end

    // Backpressure
    clear_pulse();
    put_tap(1); put_tap(2); put_tap(3); put_tap(4);
    ex_ready = 1'b0;
    put_sample(32'd2);
    begin
      int n = 0;
      while (!valid0 && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    chk("bp_first", s0, 32'd2);
    for (int i = 0; i < 10; i++) begin
      samp_v = 1'b1; samp_d = $urandom;
      @(negedge clk);
      chk("bp_ready", {31'b0, ready0}, 32'd0);
      chk("bp_valid", {31'b0, valid0}, 32'd1);
      chk("bp_hold", s0, 32'd2);
    end
    samp_v = 1'b0; ex_ready = 1'b1;
    @(negedge clk);
    chk("bp_consumed", {31'b0, valid0}, 32'd0);
    chk("bp_idle", {31'b0, ready0}, 32'd1);
    put_sample(32'd3);
    get_result("bp_next", 1'b0, 32'd7, N);

    // Clear during the second MAC cycle
    put_sample(32'd1);
    @(negedge clk);
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    chk("clr_busy", {31'b0, busy0}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      chk("clr_novalid", {31'b0, valid0}, 32'd0);
      @(negedge clk);
    end
    put_tap(32'd7);
    put_sample(32'd1);
    get_result("clr_tap0", 1'b0, 32'd7, N);

    // Tap pointer wrap
    clear_pulse();
    put_tap(5); put_tap(6); put_tap(7); put_tap(8); put_tap(9);
    put_sample(32'd1);
    get_result("wrap", 1'b0, 32'd9, N);

    // Asynchronous reset mid-MAC
    put_sample(32'd5);
    @(negedge clk);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_ready", {31'b0, ready0}, 32'd1);
    chk("arst_valid", {31'b0, valid0}, 32'd0);
    chk("arst_sample", s0, 32'd0);
    chk("arst_busy", {31'b0, busy0}, 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    put_tap(32'd3);
    put_sample(32'd2);
    get_result("arst_after", 1'b0, 32'd6, N);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      tap_v    = ($urandom_range(0, 2) == 0);
      tap_d    = $urandom;
      samp_v   = $urandom_range(0, 1) == 1;
      samp_d   = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 15);
      ex_ready = ($urandom_range(0, 3) != 0);
      clear_i  = ($urandom_range(0, 49) == 0);
      @(negedge clk);
    end
    tap_v = 1'b0; samp_v = 1'b0; clear_i = 1'b0; ex_ready = 1'b1;
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
